full_adder: RTL and testbench
=============================

// Module: full_adder
// PURPOSE
//   Registered WIDTH-bit ripple-carry full adder: A = x + y + cin, cout = carry out.
//   Leaf arithmetic cell used as the top-level DUT of the co-simulation bench.
//   The bench drives x/y/cin and samples A/cout on every change.
//   Built from per-bit 1-bit full-adder cells chained in a generate loop.
//   The default WIDTH=1 gives the classic 1-bit full-adder truth table.
// PARAMETERS
//   WIDTH    1  operand width in bits (>=1)
//   REG_OUT  1  1: outputs registered (1-cycle latency); 0: combinational outputs
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous reset, active low
//   in_valid   in   1      x/y/cin qualify this cycle
//   x          in   WIDTH  operand a
//   y          in   WIDTH  operand b
//   cin        in   1      carry in
//   A          out  WIDTH  sum, low WIDTH bits of x+y+cin
//   cout       out  1      carry out, bit WIDTH of x+y+cin
//   out_valid  out  1      A/cout hold a fresh result
//   ovf        out  1      signed overflow (only with FULL_ADDER_OVF_EN)
// BEHAVIOUR
//   - Bit i: s[i] = x[i]^y[i]^c[i]; c[i+1] = x[i]&y[i] | c[i]&(x[i]^y[i]); c[0]=cin.
//   - A = s[WIDTH-1:0], cout = c[WIDTH]; unsigned, no saturation, wraps mod 2^WIDTH.
//   - REG_OUT=1: if in_valid at a rising clk edge, A/cout load the result;
//     out_valid <= in_valid every edge. Latency exactly 1 cycle.
//   - REG_OUT=1, in_valid=0: A/cout hold their last value; out_valid drops to 0.
//   - Back-to-back in_valid: one result per cycle, no bubbles, no backpressure.
//   - rst_n low (any time, async): A=0, cout=0, out_valid=0, ovf=0, held until
//     the first rising clk after rst_n goes high. Reset mid-stream discards the
//     in-flight result.
//   - REG_OUT=0: A/cout/ovf purely combinational from x/y/cin; out_valid=in_valid;
//     clk/rst_n unused.
//   - X/Z on any operand bit propagates as X to the dependent sum/carry bits in
//     simulation. No X-masking logic.
//   - Boundaries (WIDTH=1): 1+1+1 -> A=1,cout=1; 0+0+0 -> A=0,cout=0.
//     All-ones + 0 + cin=1 -> A=0, cout=1 (full carry ripple).
// CONFIGURATION
//   FULL_ADDER_OVF_EN defined: add port ovf = c[WIDTH] ^ c[WIDTH-1] (two's-complement
//     overflow). It is registered and reset alongside A when REG_OUT=1.
//   Not defined: ovf port and its logic are absent. All other behaviour is identical.
// TESTING
//   1. WIDTH=1, REG_OUT=1: sweep all 8 {x,y,cin} with in_valid=1 -> one cycle later
//      {cout,A} = 00,01,01,10,01,10,10,11 for inputs 000..111.
//   2. rst_n=0 asserted between clock edges -> A=0,cout=0,out_valid=0 immediately;
//      release, apply x=1,y=1,cin=0 -> A=0,cout=1 one cycle later.
//   3. WIDTH=8: x=8'hFF,y=8'h00,cin=1 -> A=8'h00,cout=1; x=8'h7F,y=8'h01,cin=0
//      -> A=8'h80,cout=0, ovf=1 with FULL_ADDER_OVF_EN.
//   4. in_valid pulse then low for 3 cycles -> out_valid high 1 cycle,
//      A/cout stay at the pulse's result.
//   5. REG_OUT=0: change x 0->1 with y=0,cin=0 -> A=1 in the same delta, no clock needed.
//   6. x=1'bx,y=0,cin=0 -> A=x,cout=0 after the register (X propagates, no crash).

Source files
------------

// File: rtl/full_adder.sv
// Ripple-carry adder of WIDTH per-bit full-adder cells, with optionally registered outputs.
// FULL_ADDER_OVF_EN adds a two's-complement overflow output.
module full_adder #(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] A,
  output logic             cout,
  output logic             out_valid
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic p;
    assign p      = x[i] ^ y[i];
    assign s[i]   = p ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & p);
  end

  logic ovf_d;
  assign ovf_d = c[WIDTH] ^ c[WIDTH-1];

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] a_q;
    logic             cout_q;
    logic             valid_q;
    logic             ovf_q;

    // Result registers only load on valid input; the valid flag follows every edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q     <= '0;
        cout_q  <= 1'b0;
        ovf_q   <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= in_valid;
        if (in_valid) begin
          a_q    <= s;
          cout_q <= c[WIDTH];
          ovf_q  <= ovf_d;
        end
      end
    end

    assign A         = a_q;
    assign cout      = cout_q;
    assign out_valid = valid_q;
`ifdef FULL_ADDER_OVF_EN
    assign ovf       = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign A         = s;
    assign cout      = c[WIDTH];
    assign out_valid = in_valid;
`ifdef FULL_ADDER_OVF_EN
    assign ovf       = ovf_d;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_d;
`endif
  end

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: 1-bit registered, 8-bit registered and 1-bit combinational instances,
// checked against arithmetic x + y + cin.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // 1-bit registered
  logic v1 = 1'b0, x1 = 1'b0, y1 = 1'b0, ci1 = 1'b0;
  logic a1, co1, ov1;
  // 8-bit registered
  logic v8 = 1'b0, ci8 = 1'b0;
  logic [7:0] x8 = '0, y8 = '0, a8;
  logic co8, ov8;
  // 1-bit combinational
  logic v0 = 1'b0, x0 = 1'b0, y0 = 1'b0, ci0 = 1'b0;
  logic a0, co0, ovv0;
`ifdef FULL_ADDER_OVF_EN
  logic ovf1, ovf8, ovf0;
`endif

  full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .x(x1), .y(y1), .cin(ci1),
    .A(a1), .cout(co1), .out_valid(ov1)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .x(x8), .y(y8), .cin(ci8),
    .A(a8), .cout(co8), .out_valid(ov8)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  full_adder #(.WIDTH(1), .REG_OUT(1'b0)) u_comb (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .x(x0), .y(y0), .cin(ci0),
    .A(a0), .cout(co0), .out_valid(ovv0)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ovf0)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference for the 8-bit instance: held result plus valid flag.
  int  m8_sum  = 0;
  bit  m8_ovf  = 1'b0;
  bit  m8_vld  = 1'b0;

  task automatic step8(input logic [7:0] xa, input logic [7:0] yb, input logic ci,
                       input logic vld, input string tag);
    int sx, sy, ss;
    x8 = xa; y8 = yb; ci8 = ci; v8 = vld;
    tick();
    m8_vld = vld;
    if (vld) begin
      m8_sum = int'(xa) + int'(yb) + int'(ci);
      sx = xa[7] ? int'(xa) - 256 : int'(xa);
      sy = yb[7] ? int'(yb) - 256 : int'(yb);
      ss = sx + sy + int'(ci);
      m8_ovf = (ss > 127) || (ss < -128);
    end
    chk({tag, "_sum"}, 64'(a8), 64'(m8_sum % 256));
    chk({tag, "_cout"}, 64'(co8), 64'(m8_sum / 256));
    chk({tag, "_vld"}, 64'(ov8), 64'(m8_vld));
`ifdef FULL_ADDER_OVF_EN
    chk({tag, "_ovf"}, 64'(ovf8), 64'(m8_ovf));
`endif
  endtask

  initial begin
    int s;
    logic [2:0] bits;
    logic [1:0] hold1;

    // Reset state
    #3;
    chk("rst_a1", 64'(a1), 64'd0);
    chk("rst_co1", 64'(co1), 64'd0);
    chk("rst_v1", 64'(ov1), 64'd0);
    chk("rst_a8", 64'(a8), 64'd0);
    chk("rst_v8", 64'(ov8), 64'd0);
    #4 rst_n = 1'b1;
    tick();

    // Truth-table sweep, registered and combinational
    for (int i = 0; i < 8; i++) begin
      bits = 3'(i);
      x1 = bits[2]; y1 = bits[1]; ci1 = bits[0]; v1 = 1'b1;
      x0 = bits[2]; y0 = bits[1]; ci0 = bits[0]; v0 = 1'b1;
      s = int'(bits[2]) + int'(bits[1]) + int'(bits[0]);
      #1;
      chk("comb_tt", 64'({co0, a0}), 64'(s));
      chk("comb_vld", 64'(ovv0), 64'd1);
      tick();
      chk("reg_tt", 64'({co1, a1}), 64'(s));
      chk("reg_vld", 64'(ov1), 64'd1);
    end

    // Pulse then idle: result holds, valid drops
    x1 = 1'b1; y1 = 1'b0; ci1 = 1'b1; v1 = 1'b1;
    tick();
    chk("pulse_res", 64'({co1, a1}), 64'd2);
    chk("pulse_vld", 64'(ov1), 64'd1);
    hold1 = 2'd2;
    for (int i = 0; i < 3; i++) begin
      v1 = 1'b0; x1 = 1'b0; y1 = 1'b0; ci1 = 1'b0;
      tick();
      chk("idle_hold", 64'({co1, a1}), 64'(hold1));
      chk("idle_vld", 64'(ov1), 64'd0);
    end

    // Async reset between edges discards in-flight data
    x1 = 1'b1; y1 = 1'b1; ci1 = 1'b1; v1 = 1'b1;
    tick();
    chk("pre_rst", 64'({co1, a1}), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_res", 64'({co1, a1}), 64'd0);
    chk("async_rst_vld", 64'(ov1), 64'd0);
    chk("async_rst_a8", 64'(a8), 64'd0);
    m8_sum = 0; m8_ovf = 1'b0; m8_vld = 1'b0;
    #1 rst_n = 1'b1;
    x1 = 1'b1; y1 = 1'b1; ci1 = 1'b0; v1 = 1'b1;
    tick();
    chk("post_rst_res", 64'({co1, a1}), 64'd2);
    chk("post_rst_vld", 64'(ov1), 64'd1);

    // 8-bit boundaries
    step8(8'hFF, 8'h00, 1'b1, 1'b1, "ripple");
    step8(8'h7F, 8'h01, 1'b0, 1'b1, "ovf_pos");
    step8(8'h80, 8'h80, 1'b0, 1'b1, "ovf_neg");
    step8(8'h00, 8'h00, 1'b0, 1'b1, "zero");

    // Random 8-bit traffic with random valid gaps
    for (int i = 0; i < 40; i++) begin
      step8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), "rand");
    end

    // Combinational path: x 0->1 without a clock edge
    v0 = 1'b1; x0 = 1'b0; y0 = 1'b0; ci0 = 1'b0;
    #1;
    chk("comb_x0", 64'(a0), 64'd0);
    x0 = 1'b1;
    #0;
    #0;
    chk("comb_x1", 64'(a0), 64'd1);
    v0 = 1'b0;
    #1;
    chk("comb_vld0", 64'(ovv0), 64'd0);

    // X on an operand reaches the sum but not the carry
    x1 = 1'bx; y1 = 1'b0; ci1 = 1'b0; v1 = 1'b1;
    tick();
    chk("x_sum", 64'(a1), {63'd0, 1'bx});
    chk("x_cout", 64'(co1), 64'd0);
    v1 = 1'b0; x1 = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
